// File: rtl/mem_arb_defs.sv
// Shared constants for the unified memory port arbiter.
//   state_t   : arbiter FSM state encodings
//   GRANT_*   : grant/last_grant encodings (CPU=0, EXT=1)
//   CNT_W     : wait-state counter width
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    ACK    = 2'b10
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_EXT = 1'b1;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req_a, req_b : requests (a = CPU side, b = EXT side)
//   last         : side granted most recently (0 = a, 1 = b)
//   gnt          : chosen side (0 = a, 1 = b), meaningful when valid
//   valid        : at least one request present
module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt,
  output logic valid
);

  // On a tie the side opposite the last winner goes next.
  always_comb begin
    valid = req_a | req_b;
    gnt   = (req_a & req_b) ? ~last : req_b;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified instruction/data memory port between the CPU and
// the EXT (loader/debug) requester, with a fixed MEM_LAT wait-state access.
//   clk, rst                  : clock, async active-low reset
//   cpu_req/we/addr/wdata     : CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack        : CPU read data (registered), one-cycle ack
//   cpu_stall                 : cpu_req & ~cpu_ack
//   ext_req/we/addr/wdata     : EXT request, held until ext_ack
//   ext_rdata, ext_ack        : EXT read data (registered), one-cycle ack
//   mem_en/we/addr/wdata      : memory port (word-aligned address)
//   mem_rdata                 : memory read data, valid in last ACCESS cycle
//   busy                      : high in ACCESS and ACK
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_ack,
  output logic             cpu_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [WIDTH-1:0] ext_addr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic [WIDTH-1:0] ext_rdata,
  output logic             ext_ack,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               grant;
  logic               last_grant;
  logic               lat_we;
  logic [WIDTH-1:0]   lat_addr;
  logic [WIDTH-1:0]   lat_wdata;
  logic               arb_gnt;
  logic               arb_valid;
  logic               last_cyc;

  rr_arb2 u_rr_arb2 (
    .req_a (cpu_req),
    .req_b (ext_req),
    .last  (last_grant),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  assign last_cyc = (cnt == CNT_W'(MEM_LAT));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = ACCESS;
      ACCESS:  if (last_cyc)  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, wait-state counter, round-robin history, read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      grant      <= GRANT_CPU;
      last_grant <= GRANT_EXT;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant     <= arb_gnt;
            cnt       <= CNT_W'(1);
            lat_we    <= (arb_gnt == GRANT_EXT) ? ext_we    : cpu_we;
            lat_addr  <= (arb_gnt == GRANT_EXT) ? ext_addr  : cpu_addr;
            lat_wdata <= (arb_gnt == GRANT_EXT) ? ext_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          if (last_cyc) begin
            if (!lat_we) begin
              if (grant == GRANT_EXT) ext_rdata <= mem_rdata;
              else                    cpu_rdata <= mem_rdata;
            end
            last_grant <= grant;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and latched grant.
  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    ext_ack = 1'b0;
    busy    = 1'b0;
    case (state)
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        busy   = 1'b1;
      end
      ACK: begin
        cpu_ack = (grant == GRANT_CPU);
        ext_ack = (grant == GRANT_EXT);
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr  = {lat_addr[WIDTH-1:2], 2'b00};
  assign mem_wdata = lat_wdata;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified instruction/data memory port between two requesters.
- CPU requester: the multicycle control/datapath, for fetch and LW/SW.
- EXT requester: the program loader/debug port.
- Sequences each access through a fixed wait-state count and returns read data plus a one-cycle acknowledge.
- Drives a stall so the control FSM holds its current state until its access completes.

Parameters:
WIDTH, 32, data and address width in bits
MEM_LAT, 2, memory access cycles per transfer; legal range 1..7

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  CPU write enable (1=SW, 0=fetch/LW)
cpu_addr  in  WIDTH  CPU byte address
cpu_wdata  in  WIDTH  CPU write data
cpu_rdata  out  WIDTH  CPU read data, registered
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
ext_req  in  1  EXT access request; held until ext_ack
ext_we  in  1  EXT write enable
ext_addr  in  WIDTH  EXT byte address
ext_wdata  in  WIDTH  EXT write data
ext_rdata  out  WIDTH  EXT read data, registered
ext_ack  out  1  one-cycle completion pulse to EXT
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  WIDTH  word address: granted addr with [1:0] forced to 0
mem_wdata  out  WIDTH  granted write data
mem_rdata  in  WIDTH  memory read data; valid in the last ACCESS cycle
busy  out  1  high in ACCESS and ACK

Behaviour:
Reset (rst=0, async, any state):
- State goes to IDLE; counter and grant go to 0.
- last_grant=EXT, so the CPU wins the first tie.
- All outputs are 0, including cpu_rdata and ext_rdata.
- Reset mid-access abandons the transfer; no ack is issued.

State IDLE:
- mem_en=0, busy=0.
- Neither req: stay in IDLE.
- One req: grant it.
- Both reqs: grant the side opposite last_grant (round-robin).
- On grant: latch grant, we, addr and wdata into internal registers; cnt<=1; go to ACCESS.

State ACCESS:
- mem_en=1, mem_we=latched we; mem_addr/mem_wdata come from the latched registers.
- Outputs are stable for exactly MEM_LAT cycles.
- cnt increments each cycle.
- When cnt==MEM_LAT:
  - On a read, capture mem_rdata into the granted side's rdata register.
  - Update last_grant to the granted side.
  - Go to ACK.

State ACK:
- mem_en=0; assert the granted side's ack for exactly one cycle; go to IDLE.
- Requests are not arbitrated in ACK. A req still high here is a stale hold, not a new request.

Timing and throughput:
- Request sampled in IDLE at cycle 0 → ACCESS in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1 → IDLE in cycle MEM_LAT+2.
- Sustained throughput is one access per MEM_LAT+2 cycles.

Data and request rules:
- rdata registers hold their value until the next read completes for that side.
- Writes leave the rdata registers unchanged.
- A requester deasserting req during ACCESS does not abort the transfer; ack is still pulsed.
- Changes to the requester's addr, wdata or we during ACCESS are ignored.
- Only one ack is asserted in any cycle. cpu_ack and ext_ack are never simultaneous.
- cpu_stall is high from cpu_req rising until the ack cycle, and low in the ack cycle.
- cnt is 3 bits and never wraps within a legal MEM_LAT.

Decomposition:
- Shared constants file mem_arb_defs:
  - state encodings IDLE=2'b00, ACCESS=2'b01, ACK=2'b10
  - GRANT_CPU=1'b0, GRANT_EXT=1'b1
- Sub-module rr_arb2: combinational two-way round-robin pick.
  - Inputs: req_a, req_b, last.
  - Outputs: gnt, valid.
- The FSM, latches and counter stay in the top module.

Test Plan:
1. Reset, then CPU read at 0x00000010, MEM_LAT=2, memory returns 0x8C020004 → mem_en high in cycles 1–2, mem_addr=0x10, cpu_ack in cycle 3, cpu_rdata=0x8C020004, cpu_stall high in cycles 0–2.
2. Both reqs in the same cycle after reset (CPU read 0x0, EXT write 0x100 data 0xDEADBEEF) → CPU served first (ack cycle 3). EXT granted at cycle 4, mem_we=1 in cycles 5–6 with addr 0x100 and data 0xDEADBEEF, ext_ack in cycle 7.
3. Both reqs held continuously for 4 transfers → grants alternate CPU, EXT, CPU, EXT; acks in cycles 3, 7, 11, 15.
4. CPU addr 0x00000013 → mem_addr=0x00000010. EXT write → ext_rdata keeps its previous value.
5. rst pulsed low in the second ACCESS cycle of an EXT write → no ext_ack; all outputs 0 immediately. Next CPU request is granted first and completes normally.
6. MEM_LAT=1 and MEM_LAT=7 builds, single CPU read → ack in cycle 2 and cycle 8 respectively; mem_en high for exactly 1 and 7 cycles.
